box_field: RTL

Parametrised destructible-box layer for the Bomberman playfield. Holds up to `NUM_BOXES` breakable boxes at build-time positions, each with an alive flag. Each box is tested against the VGA pixel stream for sprite drawing and against Bomberman's position for movement blocking. When an explosion event arrives, a scanner FSM clears the alive flag of every box in the blast cross. Sits beside the wall layer and feeds the top-level pixel mux, movement logic and score logic.

---
 rtl/bomber_pkg.sv | 33 +++
 rtl/box_field_if.sv | 24 ++
 rtl/box_rom.sv | 32 +++
 rtl/box_field.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bomber_pkg.sv
// Shared definitions for the Bomberman playfield layers: coordinate widths,
// direction bit positions, scanner FSM encoding and sprite/blast defaults.
// Imported by every playfield block (box layer, interface, ROM users).
package bomber_pkg;

    localparam int COORD_W = 10;            // screen coordinate width
    localparam int CALC_W  = COORD_W + 1;   // one guard bit for add/sub

    // Bit positions inside the 4-bit blocked vector
    localparam int DIR_LEFT  = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_DOWN  = 3;

    // Sprite and blast defaults
    localparam int NUM_BOXES_DEF = 8;
    localparam int TILE_DEF      = 16;
    localparam int BOMBER_DEF    = 16;
    localparam int E_NEG_DEF     = 48;
    localparam int E_POS_DEF     = 63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Zero-extend a screen coordinate into the unsigned calculation width
    function automatic logic [CALC_W-1:0] ext(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/box_field_if.sv
// Explosion request/completion bus between the bomb logic and the box layer.
// Ports: exp_valid/e_x/e_y (request), exp_ready (idle), exp_done/destroyed_cnt (result).
// master = bomb logic, slave = box layer.
interface box_field_if;
    import bomber_pkg::*;

    logic               exp_valid;
    logic [COORD_W-1:0] e_x;
    logic [COORD_W-1:0] e_y;
    logic               exp_ready;
    logic               exp_done;
    logic [5:0]         destroyed_cnt;

    modport master (
        output exp_valid, e_x, e_y,
        input  exp_ready, exp_done, destroyed_cnt
    );

    modport slave (
        input  exp_valid, e_x, e_y,
        output exp_ready, exp_done, destroyed_cnt
    );

endinterface

// File: rtl/box_rom.sv
// Box sprite colour ROM, 16x16 entries of 12-bit RGB, indexed by row/col.
// Ports: clk, reset_n, row, col in; rgb out. Latency: 1 cycle (registered read).
// No backpressure: a new address is accepted every cycle.
module box_rom (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [11:0] rgb
);

    logic [11:0] rgb_d;

    // Dark frame, a lighter diagonal cross and a wooden fill
    always_comb begin
        rgb_d = 12'hB85;
        if (row == 4'd0 || row == 4'd15 || col == 4'd0 || col == 4'd15) begin
            rgb_d = 12'h630;
        end else if (row == col || row == (4'd15 - col)) begin
            rgb_d = 12'h953;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb <= 12'h000;
        end else begin
            rgb <= rgb_d;
        end
    end

endmodule

// File: rtl/box_field.sv
// Destructible box layer: alive flags, pixel sprite lookup, movement blocking, blast scanner.
// Ports: clk/reset_n/restart, b_x/b_y, v_x/v_y, explosion bus, boxes_alive, bomberman_blocked, box_on, rgb_out.
// Latency: blocking 1 cycle, pixel 2 cycles, scan NUM_BOXES+1 cycles; requests dropped while busy.
module box_field
    import bomber_pkg::*;
#(
    parameter int NUM_BOXES = NUM_BOXES_DEF,
    parameter int TILE_W    = TILE_DEF,
    parameter int TILE_H    = TILE_DEF,
    parameter int B_W       = BOMBER_DEF,
    parameter int B_H       = BOMBER_DEF,
    parameter int E_NEG     = E_NEG_DEF,
    parameter int E_POS     = E_POS_DEF,
    parameter logic [NUM_BOXES*COORD_W-1:0] BOX_X = '0,
    parameter logic [NUM_BOXES*COORD_W-1:0] BOX_Y = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 restart,
    input  logic [COORD_W-1:0]   b_x,
    input  logic [COORD_W-1:0]   b_y,
    input  logic [COORD_W-1:0]   v_x,
    input  logic [COORD_W-1:0]   v_y,
    box_field_if.slave           ex_bus,
    output logic [NUM_BOXES-1:0] boxes_alive,
    output logic [3:0]           bomberman_blocked,
    output logic                 box_on,
    output logic [11:0]          rgb_out
);

    localparam int IDX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BOXES - 1);
    localparam logic [CALC_W-1:0] ONE  = CALC_W'(1);
    localparam logic [CALC_W-1:0] TW   = CALC_W'(TILE_W);
    localparam logic [CALC_W-1:0] TH   = CALC_W'(TILE_H);
    localparam logic [CALC_W-1:0] BW   = CALC_W'(B_W);
    localparam logic [CALC_W-1:0] BH   = CALC_W'(B_H);
    localparam logic [CALC_W-1:0] ENEG = CALC_W'(E_NEG);
    localparam logic [CALC_W-1:0] EPOS = CALC_W'(E_POS);

    // ---------------- state ----------------
    scan_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [5:0]          dcnt_q, dcnt_d;
    logic                done_q, done_d;
    logic [COORD_W-1:0]  ex_q, ex_d, ey_q, ey_d;
    logic [NUM_BOXES-1:0] alive_q, alive_d;

    // ---------------- blast arms from the latched origin ----------------
    logic [CALC_W-1:0] ex11, ey11;
    logic [CALC_W-1:0] hx_lo, hx_hi, hy_lo, hy_hi;
    logic [CALC_W-1:0] vx_lo, vx_hi, vy_lo, vy_hi;

    assign ex11  = ext(ex_q);
    assign ey11  = ext(ey_q);
    // Reach toward the origin saturates at 0 rather than wrapping
    assign hx_lo = (ex11 >= ENEG) ? ex11 - ENEG : '0;
    assign hx_hi = ex11 + EPOS;
    assign hy_lo = ey11;
    assign hy_hi = ey11 + TH - ONE;
    assign vy_lo = (ey11 >= ENEG) ? ey11 - ENEG : '0;
    assign vy_hi = ey11 + EPOS;
    assign vx_lo = ex11;
    assign vx_hi = ex11 + TW - ONE;

    // ---------------- per-box tests ----------------
    logic [CALC_W-1:0]    bxb, byb;
    logic [NUM_BOXES-1:0] blast_hit, pix_hit;
    logic [NUM_BOXES-1:0] blk_l, blk_r, blk_u, blk_d;
    logic [3:0]           pix_row [NUM_BOXES];
    logic [3:0]           pix_col [NUM_BOXES];

    assign bxb = ext(b_x);
    assign byb = ext(b_y);

    for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box
        logic [CALC_W-1:0] bx, by, bx_end, by_end, dx, dy;
        logic              ov_x, ov_y;

        assign bx     = ext(BOX_X[gi*COORD_W +: COORD_W]);
        assign by     = ext(BOX_Y[gi*COORD_W +: COORD_W]);
        assign bx_end = bx + TW - ONE;
        assign by_end = by + TH - ONE;

        // Box rectangle overlaps the horizontal or the vertical arm
        assign blast_hit[gi] =
            ((bx <= hx_hi) && (bx_end >= hx_lo) && (by <= hy_hi) && (by_end >= hy_lo)) ||
            ((bx <= vx_hi) && (bx_end >= vx_lo) && (by <= vy_hi) && (by_end >= vy_lo));

        // Pixel left/above the box wraps to a large value and fails the compare
        assign dx          = ext(v_x) - bx;
        assign dy          = ext(v_y) - by;
        assign pix_hit[gi] = alive_q[gi] && (dx < TW) && (dy < TH);
        assign pix_row[gi] = dy[3:0];
        assign pix_col[gi] = dx[3:0];

        // Edge contact only blocks when the other axis overlaps strictly
        assign ov_y = (byb < by + TH) && (byb + BH > by);
        assign ov_x = (bxb < bx + TW) && (bxb + BW > bx);
        assign blk_l[gi] = alive_q[gi] && ov_y && (bxb == bx + TW);
        assign blk_r[gi] = alive_q[gi] && ov_y && (bxb + BW == bx);
        assign blk_u[gi] = alive_q[gi] && ov_x && (byb == by + TH);
        assign blk_d[gi] = alive_q[gi] && ov_x && (byb + BH == by);
    end

    // ---------------- movement blocking ----------------
    logic [3:0] blocked_d, blocked_q;

    always_comb begin
        blocked_d            = '0;
        blocked_d[DIR_LEFT]  = |blk_l;
        blocked_d[DIR_RIGHT] = |blk_r;
        blocked_d[DIR_UP]    = |blk_u;
        blocked_d[DIR_DOWN]  = |blk_d;
    end

    // ---------------- pixel pipeline ----------------
    logic       any_hit;
    logic [3:0] sel_row, sel_col;
    logic [3:0] row_q, col_q;
    logic       hit1_q, hit2_q;

    // Descending walk so the lowest-index hit is written last and wins
    always_comb begin
        any_hit = 1'b0;
        sel_row = '0;
        sel_col = '0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (pix_hit[i]) begin
                any_hit = 1'b1;
                sel_row = pix_row[i];
                sel_col = pix_col[i];
            end
        end
    end

    box_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .row     (row_q),
        .col     (col_q),
        .rgb     (rgb_out)
    );

    // ---------------- scanner FSM ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        done_d  = 1'b0;
        ex_d    = ex_q;
        ey_d    = ey_q;
        alive_d = alive_q;

        case (state_q)
            ST_IDLE: begin
                if (ex_bus.exp_valid && !done_q) begin
                    ex_d    = ex_bus.e_x;
                    ey_d    = ex_bus.e_y;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (alive_q[idx_q] && blast_hit[idx_q]) begin
                    alive_d[idx_q] = 1'b0;
                    cnt_d          = cnt_q + 6'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                dcnt_d  = cnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart overrides any clear or completion in the same cycle
        if (restart) begin
            alive_d = '1;
            state_d = ST_IDLE;
            done_d  = 1'b0;
            dcnt_d  = dcnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            done_q    <= 1'b0;
            ex_q      <= '0;
            ey_q      <= '0;
            alive_q   <= '1;
            blocked_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            done_q    <= done_d;
            ex_q      <= ex_d;
            ey_q      <= ey_d;
            alive_q   <= alive_d;
            blocked_q <= blocked_d;
            row_q     <= sel_row;
            col_q     <= sel_col;
            hit1_q    <= any_hit;
            hit2_q    <= hit1_q;
        end
    end

    // Ready is held low during the done pulse so it returns one cycle later
    assign ex_bus.exp_ready     = (state_q == ST_IDLE) && !done_q;
    assign ex_bus.exp_done      = done_q;
    assign ex_bus.destroyed_cnt = dcnt_q;
    assign boxes_alive          = alive_q;
    assign bomberman_blocked    = blocked_q;
    assign box_on               = hit2_q;

endmodule
